// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES MixColumns block.
// Optional inverse support is enabled in the top by AES_MIXCOL_INV_EN.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NUM_COLS = 4;
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (AES_POLY & {8{a[7]}});
  endfunction

endpackage

// File: rtl/aes_mixcolumn.sv
// Combinational forward MixColumns on one 32-bit column.
// Row 0 is the most significant byte.
module aes_mixcolumn
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3*a is xtime(a) ^ a
  assign o_col[31:24] = w_x0 ^ w_x1 ^ w_a1 ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_x1 ^ w_x2 ^ w_a2 ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ w_x3 ^ w_a3;
  assign o_col[7:0]   = w_x0 ^ w_a0 ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_mixcolumn_ctrl.sv
// Column-serial AES MixColumns controller: one column per RUN cycle.
// Define AES_MIXCOL_INV_EN to add the in_inv port and InvMixColumns.
module aes_mixcolumn_ctrl
  import aes_pkg::*;
(
`ifdef AES_MIXCOL_INV_EN
  input  logic         in_inv,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_data;
  logic [127:0] r_res;
  logic         r_byp;
  logic         r_out_valid;
  logic         r_busy;

  logic [31:0]  w_col;
  logic [31:0]  w_pre;
  logic [31:0]  w_mixed;
  logic [31:0]  w_wr;

  always_comb begin
    w_col = r_data[127:96];
    unique case (r_cnt)
      2'd0: w_col = r_data[127:96];
      2'd1: w_col = r_data[95:64];
      2'd2: w_col = r_data[63:32];
      2'd3: w_col = r_data[31:0];
      default: w_col = r_data[127:96];
    endcase
  end

`ifdef AES_MIXCOL_INV_EN
  logic       r_inv;
  logic [7:0] w_u;
  logic [7:0] w_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_inv <= in_inv;
    end
  end

  // InvMixColumns = forward matrix applied after this preprocessing
  assign w_u = xtime(xtime(w_col[31:24] ^ w_col[15:8]));
  assign w_v = xtime(xtime(w_col[23:16] ^ w_col[7:0]));

  assign w_pre = r_inv ? {w_col[31:24] ^ w_u,
                          w_col[23:16] ^ w_v,
                          w_col[15:8]  ^ w_u,
                          w_col[7:0]   ^ w_v}
                       : w_col;
`else
  assign w_pre = w_col;
`endif

  aes_mixcolumn u_mixcolumn (
    .i_col (w_pre),
    .o_col (w_mixed)
  );

  assign w_wr = r_byp ? w_col : w_mixed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_data      <= '0;
      r_res       <= '0;
      r_byp       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_state;
            r_byp   <= in_bypass;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          unique case (r_cnt)
            2'd0: r_res[127:96] <= w_wr;
            2'd1: r_res[95:64]  <= w_wr;
            2'd2: r_res[63:32]  <= w_wr;
            2'd3: r_res[31:0]   <= w_wr;
            default: r_res[127:96] <= w_wr;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == LAST_COL) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_state = r_res;
  assign busy      = r_busy;

endmodule
